dxt_mem_arbiter: RTL and testbench

DXT_MEM_ARBITER -- requirements
Module: dxt_mem_arbiter

---
 rtl/i3c_pkg.sv | 45 ++++
 rtl/dxt_rr_arb2.sv | 36 +++
 rtl/dxt_mem_arbiter.sv | 111 +++++++++++
 tb/tb_dxt_mem_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i3c_pkg.sv
// Shared i3c memory-path types: DAT/DCT word types plus the requester and
// memory bundles used by the DAT/DCT memory arbiter.
package i3c_pkg;

    localparam int unsigned DatAw    = 8;
    localparam int unsigned DatDw    = 64;
    localparam int unsigned DctAw    = 8;
    localparam int unsigned DctDw    = 128;
    localparam int unsigned MemAwMax = 16;
    localparam int unsigned MemDwMax = 128;

    typedef logic [DatDw-1:0] dat_word_t;
    typedef logic [DctDw-1:0] dct_word_t;

    // Bundles are sized for the widest memory; narrower instances zero-extend.
    typedef struct packed {
        logic                req;
        logic                write;
        logic [MemAwMax-1:0] addr;
        logic [MemDwMax-1:0] wdata;
        logic [MemDwMax-1:0] wmask;
    } mem_req_t;

    typedef struct packed {
        logic [MemDwMax-1:0] rdata;
    } mem_rsp_t;

    typedef enum logic {
        GntHw = 1'b0,
        GntSw = 1'b1
    } gnt_sel_e;

    // Two-way round robin: a lone request wins, contention goes to the loser of last time.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input gnt_sel_e last);
        logic [1:0] gnt;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == GntSw) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        return gnt;
    endfunction

endpackage

// File: rtl/dxt_rr_arb2.sv
// Two-way round-robin arbiter; bit 0 is the controller FSM, bit 1 the CSR side.
module dxt_rr_arb2
    import i3c_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    gnt_sel_e last_gnt_q;
    gnt_sel_e last_gnt_d;

    // Grant decode and last-grant update; idle cycles keep the history.
    always_comb begin
        gnt_o      = rr_pick(req_i, last_gnt_q);
        last_gnt_d = last_gnt_q;
        if (gnt_o[0]) begin
            last_gnt_d = GntHw;
        end else if (gnt_o[1]) begin
            last_gnt_d = GntSw;
        end else begin
            last_gnt_d = last_gnt_q;
        end
    end

    // Reset to SW so the controller wins the first contention.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_gnt_q <= GntSw;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

endmodule

// File: rtl/dxt_mem_arbiter.sv
// Shares one single-port RAM between the i3c controller FSM and CSR accesses,
// with round-robin arbitration, read-response routing and a conflict counter.
module dxt_mem_arbiter
    import i3c_pkg::*;
#(
    parameter int unsigned AddrW = i3c_pkg::DatAw,
    parameter int unsigned DataW = 64,
    parameter int unsigned CntW  = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             hw_req_i,
    input  logic             hw_write_i,
    input  logic [AddrW-1:0] hw_addr_i,
    input  logic [DataW-1:0] hw_wdata_i,
    input  logic [DataW-1:0] hw_wmask_i,
    output logic             hw_gnt_o,
    output logic             hw_rvalid_o,
    output logic [DataW-1:0] hw_rdata_o,
    input  logic             sw_req_i,
    input  logic             sw_write_i,
    input  logic [AddrW-1:0] sw_addr_i,
    input  logic [DataW-1:0] sw_wdata_i,
    input  logic [DataW-1:0] sw_wmask_i,
    output logic             sw_gnt_o,
    output logic             sw_rvalid_o,
    output logic [DataW-1:0] sw_rdata_o,
    output logic             mem_req_o,
    output logic             mem_write_o,
    output logic [AddrW-1:0] mem_addr_o,
    output logic [DataW-1:0] mem_wdata_o,
    output logic [DataW-1:0] mem_wmask_o,
    input  logic [DataW-1:0] mem_rdata_i,
    output logic [CntW-1:0]  conflict_cnt_o
);

    logic [1:0]      req_s;
    logic [1:0]      gnt_s;
    mem_req_t        hw_bundle_s;
    mem_req_t        sw_bundle_s;
    mem_req_t        mux_s;
    logic            hw_rvalid_q, hw_rvalid_d;
    logic            sw_rvalid_q, sw_rvalid_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Requests are masked while in reset so no grant or memory access escapes.
    assign req_s = {sw_req_i & rst_ni, hw_req_i & rst_ni};

    dxt_rr_arb2 u_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (req_s),
        .gnt_o  (gnt_s)
    );

    // Pack both requesters and steer the granted one onto the RAM port.
    always_comb begin
        hw_bundle_s = '{req: req_s[0], write: hw_write_i, addr: MemAwMax'(hw_addr_i),
                        wdata: MemDwMax'(hw_wdata_i), wmask: MemDwMax'(hw_wmask_i)};
        sw_bundle_s = '{req: req_s[1], write: sw_write_i, addr: MemAwMax'(sw_addr_i),
                        wdata: MemDwMax'(sw_wdata_i), wmask: MemDwMax'(sw_wmask_i)};
        mux_s = '0;
        if (gnt_s[0]) begin
            mux_s = hw_bundle_s;
        end else if (gnt_s[1]) begin
            mux_s = sw_bundle_s;
        end else begin
            mux_s = '0;
        end
    end

    assign mem_req_o   = mux_s.req;
    assign mem_write_o = mux_s.write;
    assign mem_addr_o  = AddrW'(mux_s.addr);
    assign mem_wdata_o = DataW'(mux_s.wdata);
    assign mem_wmask_o = DataW'(mux_s.wmask);

    // Read-owner tracking and saturating contention count.
    always_comb begin
        hw_rvalid_d = gnt_s[0] & ~hw_write_i;
        sw_rvalid_d = gnt_s[1] & ~sw_write_i;
        cnt_d       = cnt_q;
        if ((&req_s) && (cnt_q != {CntW{1'b1}})) begin
            cnt_d = cnt_q + CntW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers; reset drops any in-flight read response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hw_rvalid_q <= 1'b0;
            sw_rvalid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            hw_rvalid_q <= hw_rvalid_d;
            sw_rvalid_q <= sw_rvalid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign hw_gnt_o       = gnt_s[0];
    assign sw_gnt_o       = gnt_s[1];
    assign hw_rvalid_o    = hw_rvalid_q;
    assign sw_rvalid_o    = sw_rvalid_q;
    assign hw_rdata_o     = mem_rdata_i;
    assign sw_rdata_o     = mem_rdata_i;
    assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_dxt_mem_arbiter.sv
// Directed bench for dxt_mem_arbiter with a behavioural single-port RAM.
module tb_dxt_mem_arbiter;
    import i3c_pkg::*;

    localparam int AW = i3c_pkg::DatAw;
    localparam int DW = 64;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          hw_req, hw_write, sw_req, sw_write;
    logic [AW-1:0] hw_addr, sw_addr;
    logic [DW-1:0] hw_wdata, hw_wmask, sw_wdata, sw_wmask;
    logic          hw_gnt, hw_rvalid, sw_gnt, sw_rvalid;
    logic [DW-1:0] hw_rdata, sw_rdata;
    logic          mem_req, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_wmask, mem_rdata;
    logic [CW-1:0] conflict_cnt;
    logic          ram_init;
    logic [DW-1:0] ram [0:(1<<AW)-1];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dxt_mem_arbiter #(.AddrW(AW), .DataW(DW), .CntW(CW)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .hw_req_i(hw_req), .hw_write_i(hw_write), .hw_addr_i(hw_addr),
        .hw_wdata_i(hw_wdata), .hw_wmask_i(hw_wmask),
        .hw_gnt_o(hw_gnt), .hw_rvalid_o(hw_rvalid), .hw_rdata_o(hw_rdata),
        .sw_req_i(sw_req), .sw_write_i(sw_write), .sw_addr_i(sw_addr),
        .sw_wdata_i(sw_wdata), .sw_wmask_i(sw_wmask),
        .sw_gnt_o(sw_gnt), .sw_rvalid_o(sw_rvalid), .sw_rdata_o(sw_rdata),
        .mem_req_o(mem_req), .mem_write_o(mem_write), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_wmask_o(mem_wmask), .mem_rdata_i(mem_rdata),
        .conflict_cnt_o(conflict_cnt)
    );

    // Single-port RAM with bit-masked writes and one-cycle read latency.
    always @(posedge clk) begin
        if (ram_init) begin
            ram[3] <= 64'hDEAD_BEEF_CAFE_F00D;
            ram[5] <= 64'h0000_0000_0000_A5A5;
            ram[7] <= 64'h0000_0000_0000_7777;
        end else if (mem_req) begin
            if (mem_write) ram[mem_addr] <= (ram[mem_addr] & ~mem_wmask) | (mem_wdata & mem_wmask);
            else           mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_hw(input logic r, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [DW-1:0] m);
        hw_req = r; hw_write = w; hw_addr = a; hw_wdata = d; hw_wmask = m;
    endtask

    task automatic drive_sw(input logic r, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [DW-1:0] m);
        sw_req = r; sw_write = w; sw_addr = a; sw_wdata = d; sw_wmask = m;
    endtask

    task automatic apply_reset();
        drive_hw(1'b0, 1'b0, '0, '0, '0);
        drive_sw(1'b0, 1'b0, '0, '0, '0);
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_ni   = 1'b0;
        ram_init = 1'b1;
        drive_hw(1'b0, 1'b0, '0, '0, '0);
        drive_sw(1'b0, 1'b0, '0, '0, '0);
        tick();
        tick();
        ram_init = 1'b0;
        chk("rst_hw_gnt",    hw_gnt,       1'b0);
        chk("rst_sw_gnt",    sw_gnt,       1'b0);
        chk("rst_hw_rvalid", hw_rvalid,    1'b0);
        chk("rst_sw_rvalid", sw_rvalid,    1'b0);
        chk("rst_mem_req",   mem_req,      1'b0);
        chk("rst_mem_write", mem_write,    1'b0);
        chk("rst_cnt",       conflict_cnt, 4'd0);
        rst_ni = 1'b1;

        // Lone HW read of address 5
        drive_hw(1'b1, 1'b0, 8'd5, '0, '0);
        #1;
        chk("hw_alone_gnt",   hw_gnt,    1'b1);
        chk("hw_alone_sgnt",  sw_gnt,    1'b0);
        chk("hw_alone_mreq",  mem_req,   1'b1);
        chk("hw_alone_maddr", mem_addr,  8'd5);
        chk("hw_alone_mwr",   mem_write, 1'b0);
        tick();
        drive_hw(1'b0, 1'b0, '0, '0, '0);
        chk("hw_alone_rvalid", hw_rvalid, 1'b1);
        chk("hw_alone_rdata",  hw_rdata,  64'hA5A5);
        chk("hw_alone_srv",    sw_rvalid, 1'b0);
        tick();
        chk("hw_alone_rv_pulse", hw_rvalid, 1'b0);

        // First contention after reset goes to HW, SW follows
        apply_reset();
        drive_hw(1'b1, 1'b0, 8'd5, '0, '0);
        drive_sw(1'b1, 1'b0, 8'd7, '0, '0);
        #1;
        chk("c1_hw_gnt", hw_gnt, 1'b1);
        chk("c1_sw_gnt", sw_gnt, 1'b0);
        tick();
        chk("c1_hw_rvalid", hw_rvalid,    1'b1);
        chk("c1_hw_rdata",  hw_rdata,     64'hA5A5);
        chk("c1_sw_rv0",    sw_rvalid,    1'b0);
        chk("c1_cnt",       conflict_cnt, 4'd1);
        drive_hw(1'b0, 1'b0, '0, '0, '0);
        #1;
        chk("c1_sw_gnt2", sw_gnt, 1'b1);
        chk("c1_hw_gnt2", hw_gnt, 1'b0);
        tick();
        drive_sw(1'b0, 1'b0, '0, '0, '0);
        chk("c1_sw_rvalid", sw_rvalid,    1'b1);
        chk("c1_sw_rdata",  sw_rdata,     64'h7777);
        chk("c1_hw_rv0",    hw_rvalid,    1'b0);
        chk("c1_cnt_hold",  conflict_cnt, 4'd1);

        // Both hold requests for six cycles: H,S,H,S,H,S
        apply_reset();
        drive_hw(1'b1, 1'b0, 8'd5, '0, '0);
        drive_sw(1'b1, 1'b0, 8'd7, '0, '0);
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("alt_hw_gnt%0d", i), hw_gnt, (i % 2) == 0);
            chk($sformatf("alt_sw_gnt%0d", i), sw_gnt, (i % 2) == 1);
            tick();
            chk($sformatf("alt_hw_rv%0d", i), hw_rvalid, (i % 2) == 0);
            chk($sformatf("alt_sw_rv%0d", i), sw_rvalid, (i % 2) == 1);
        end
        drive_hw(1'b0, 1'b0, '0, '0, '0);
        drive_sw(1'b0, 1'b0, '0, '0, '0);
        chk("alt_cnt", conflict_cnt, 4'd6);
        #1;
        chk("idle_mem_req", mem_req,   1'b0);
        chk("idle_mem_wr",  mem_write, 1'b0);
        tick();
        tick();
        chk("idle_cnt", conflict_cnt, 4'd6);
        drive_hw(1'b1, 1'b0, 8'd5, '0, '0);
        drive_sw(1'b1, 1'b0, 8'd7, '0, '0);
        #1;
        chk("idle_keep_last_hw", hw_gnt, 1'b1);
        tick();
        drive_hw(1'b0, 1'b0, '0, '0, '0);
        drive_sw(1'b0, 1'b0, '0, '0, '0);
        chk("idle_cnt7", conflict_cnt, 4'd7);
        tick();

        // SW masked write to address 3, HW reads it back
        drive_sw(1'b1, 1'b1, 8'd3, 64'h1234, 64'h0000_0000_FFFF_FFFF);
        #1;
        chk("wr_sw_gnt", sw_gnt,    1'b1);
        chk("wr_mwrite", mem_write, 1'b1);
        chk("wr_mwdata", mem_wdata, 64'h1234);
        chk("wr_mwmask", mem_wmask, 64'h0000_0000_FFFF_FFFF);
        tick();
        drive_sw(1'b0, 1'b0, '0, '0, '0);
        chk("wr_no_srv", sw_rvalid, 1'b0);
        chk("wr_no_hrv", hw_rvalid, 1'b0);
        drive_hw(1'b1, 1'b0, 8'd3, '0, '0);
        tick();
        drive_hw(1'b0, 1'b0, '0, '0, '0);
        chk("rb_hw_rvalid", hw_rvalid, 1'b1);
        chk("rb_hw_rdata",  hw_rdata,  64'hDEAD_BEEF_0000_1234);
        tick();

        // Reset during the response cycle of a read discards it
        apply_reset();
        drive_hw(1'b1, 1'b0, 8'd5, '0, '0);
        drive_sw(1'b1, 1'b0, 8'd7, '0, '0);
        tick();
        rst_ni = 1'b0;
        #1;
        chk("rip_hw_rv",   hw_rvalid,    1'b0);
        chk("rip_hw_gnt",  hw_gnt,       1'b0);
        chk("rip_sw_gnt",  sw_gnt,       1'b0);
        chk("rip_mem_req", mem_req,      1'b0);
        chk("rip_cnt",     conflict_cnt, 4'd0);
        tick();
        tick();
        drive_hw(1'b0, 1'b0, '0, '0, '0);
        drive_sw(1'b0, 1'b0, '0, '0, '0);
        rst_ni = 1'b1;
        tick();
        chk("rip_post_hrv", hw_rvalid,    1'b0);
        chk("rip_post_srv", sw_rvalid,    1'b0);
        chk("rip_post_cnt", conflict_cnt, 4'd0);
        drive_hw(1'b1, 1'b0, 8'd5, '0, '0);
        drive_sw(1'b1, 1'b0, 8'd7, '0, '0);
        #1;
        chk("rip_next_hw", hw_gnt, 1'b1);
        chk("rip_next_sw", sw_gnt, 1'b0);
        tick();
        drive_hw(1'b0, 1'b0, '0, '0, '0);
        drive_sw(1'b0, 1'b0, '0, '0, '0);

        // 2^CntW+3 contention cycles saturate the counter
        apply_reset();
        drive_hw(1'b1, 1'b0, 8'd5, '0, '0);
        drive_sw(1'b1, 1'b0, 8'd7, '0, '0);
        repeat (14) tick();
        chk("sat_cnt14", conflict_cnt, 4'd14);
        repeat (5) tick();
        chk("sat_cnt15", conflict_cnt, 4'd15);
        drive_hw(1'b0, 1'b0, '0, '0, '0);
        drive_sw(1'b0, 1'b0, '0, '0, '0);
        tick();
        chk("sat_hold", conflict_cnt, 4'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
